// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and the 16x-oversampling receiver:
//   - tx_state_t    : transmitter frame states. PARITY exists in the encoding
//                     but is only reachable when UART_TX_PARITY_EN is defined.
//   - line levels   : idle, start and stop levels of the serial line.
//   - defaults      : DATA_BITS / OVERSAMPLE values common to both directions.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DEFAULT_DATA_BITS  = 8;
    localparam int UART_DEFAULT_OVERSAMPLE = 16;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Counts oversample ticks inside one serial bit and pulses o_bit_end on the
// tick that completes the bit (the OVERSAMPLE-th tick). The counter then
// wraps to 0, so consecutive bits need no explicit restart.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_en       : counting allowed (a frame is in progress)
//   i_tick     : oversample enable pulse, one clk wide
//   i_clr      : synchronous clear of the tick counter
//   o_bit_end  : combinational pulse, high on the bit's final tick
// ---------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_tick,
    input  logic i_clr,
    output logic o_bit_end
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic [CW-1:0] r_tick_cnt;
    logic          w_last_tick;

    assign w_last_tick = (r_tick_cnt == CW'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_tick_cnt <= '0;
        end else if (i_en && i_tick) begin
            r_tick_cnt <= w_last_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    assign o_bit_end = i_en & i_tick & w_last_tick;

endmodule

// File: rtl/uart_tx_16x.sv
// ---------------------------------------------------------------------------
// uart_tx_16x
// Double-buffered UART transmitter. A byte written into the holding register
// is moved into the shift register as soon as the line is free (immediately
// from IDLE, or at the end of the stop bit for back-to-back frames), freeing
// the holding register for the next byte. Frame: start(0), DATA_BITS data
// bits LSB first, [even parity], stop(1); each bit lasts OVERSAMPLE ticks.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   t_enable   : oversample tick, one clk wide
//   load, din  : write strobe and byte; accepted only while tbr=1
//   txd        : registered serial output, idles high
//   tbr        : holding register empty
//   busy       : frame in progress
// ---------------------------------------------------------------------------
module uart_tx_16x #(
    parameter int DATA_BITS  = uart_pkg::UART_DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = uart_pkg::UART_DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 t_enable,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] din,
    output logic                 txd,
    output logic                 tbr,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    tx_state_t            r_state, w_state_next;
    logic [DATA_BITS-1:0] r_hold, w_hold_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next, w_shift_shr;
    logic [BCW-1:0]       r_bit_cnt, w_bit_cnt_next;
    logic                 r_tbr, w_tbr_next;
    logic                 r_txd, w_txd_next;
    logic                 w_bit_end;
    logic                 w_xfer;
    logic                 w_last_data;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity, w_parity_next;
`endif

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .i_en      (r_state != IDLE),
        .i_tick    (t_enable),
        .i_clr     (r_state == IDLE),
        .o_bit_end (w_bit_end)
    );

    assign w_shift_shr = r_shift >> 1;
    assign w_last_data = (r_bit_cnt == BCW'(DATA_BITS - 1));

    // Holding -> shift transfer. From IDLE it is not tied to a tick, so the
    // start bit begins one clk after the byte lands in the holding register.
    // A load in the same cycle cannot collide: it needs tbr=1, a transfer tbr=0.
    assign w_xfer = !r_tbr && ((r_state == IDLE) || (r_state == STOP && w_bit_end));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_hold    <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tbr     <= 1'b1;
            r_txd     <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_hold    <= w_hold_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tbr     <= w_tbr_next;
            r_txd     <= w_txd_next;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (w_xfer) w_state_next = START;
            START: if (w_bit_end) w_state_next = DATA;
            DATA: begin
                if (w_bit_end && w_last_data) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (w_bit_end) w_state_next = STOP;
`endif
            STOP:  if (w_bit_end) w_state_next = w_xfer ? START : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath / output next values (txd is registered from w_txd_next)
    always_comb begin
        w_hold_next    = r_hold;
        w_tbr_next     = r_tbr;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_txd_next     = r_txd;
`ifdef UART_TX_PARITY_EN
        w_parity_next  = r_parity;
`endif

        if (load && r_tbr) begin
            w_hold_next = din;
            w_tbr_next  = 1'b0;
        end else if (w_xfer) begin
            w_tbr_next  = 1'b1;
        end

        if (w_xfer) begin
            w_shift_next   = r_hold;
            w_bit_cnt_next = '0;
            w_txd_next     = UART_START_LEVEL;
`ifdef UART_TX_PARITY_EN
            w_parity_next  = ^r_hold;
`endif
        end else begin
            case (r_state)
                IDLE: w_txd_next = UART_IDLE_LEVEL;
                START: begin
                    if (w_bit_end) begin
                        w_bit_cnt_next = '0;
                        w_txd_next     = r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (w_last_data) begin
`ifdef UART_TX_PARITY_EN
                            w_txd_next = r_parity;
`else
                            w_txd_next = UART_STOP_LEVEL;
`endif
                        end else begin
                            w_shift_next   = w_shift_shr;
                            w_bit_cnt_next = r_bit_cnt + 1'b1;
                            w_txd_next     = w_shift_shr[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (w_bit_end) w_txd_next = UART_STOP_LEVEL;
`endif
                STOP: if (w_bit_end) w_txd_next = UART_IDLE_LEVEL;
                default: w_txd_next = UART_IDLE_LEVEL;
            endcase
        end
    end

    assign txd  = r_txd;
    assign tbr  = r_tbr;
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_16x.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_16x
// Drives uart_tx_16x with directed and $urandom stimulus and compares txd,
// tbr and busy every clock against a frame-level reference model: each
// accepted byte becomes a bit vector (start, data LSB first, [parity], stop)
// that is walked one entry per OVERSAMPLE ticks.
// ---------------------------------------------------------------------------
module tb_uart_tx_16x;

    localparam int DB = 8;
    localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FL = DB + 3;
`else
    localparam int FL = DB + 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          t_enable = 1'b0;
    logic          load = 1'b0;
    logic [DB-1:0] din = '0;
    logic          txd, tbr, busy;

    uart_tx_16x #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .t_enable (t_enable),
        .load     (load),
        .din      (din),
        .txd      (txd),
        .tbr      (tbr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int tbr_rise_q[$];
    logic prev_tbr = 1'b1;

    // Reference model state
    bit          m_act;
    bit          m_full;
    bit [DB-1:0] m_hold;
    bit [15:0]   m_frame;
    int          m_idx;
    int          m_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp_v);
    endtask

    function automatic bit [15:0] make_frame(input bit [DB-1:0] d);
        bit [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DB; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        f[DB+1] = ^d;
`endif
        f[FL-1] = 1'b1;
        return f;
    endfunction

    task automatic model_update(input logic r, input logic ld, input logic [DB-1:0] d, input logic te);
        bit acc;
        if (r) begin
            m_act = 0; m_full = 0; m_hold = '0; m_idx = 0; m_tick = 0;
        end else begin
            acc = ld && !m_full;
            if (m_act) begin
                if (te) begin
                    m_tick++;
                    if (m_tick == OS) begin
                        m_tick = 0;
                        m_idx++;
                        if (m_idx == FL) begin
                            if (m_full) begin
                                m_frame = make_frame(m_hold);
                                m_idx = 0;
                                m_full = 0;
                            end else begin
                                m_act = 0;
                                m_idx = 0;
                            end
                        end
                    end
                end
            end else if (m_full) begin
                m_act = 1; m_frame = make_frame(m_hold);
                m_idx = 0; m_tick = 0; m_full = 0;
            end
            if (acc) begin
                m_hold = d;
                m_full = 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic [DB-1:0] d, input logic te);
        logic exp_txd;
        rst = r; load = ld; din = d; t_enable = te;
        @(posedge clk);
        model_update(r, ld, d, te);
        #1;
        cyc++;
        if (!prev_tbr && tbr) tbr_rise_q.push_back(cyc);
        prev_tbr = tbr;
        exp_txd = m_act ? m_frame[m_idx] : 1'b1;
        chk("txd",  {31'd0, txd},  {31'd0, exp_txd});
        chk("tbr",  {31'd0, tbr},  {31'd0, !m_full});
        chk("busy", {31'd0, busy}, {31'd0, m_act});
    endtask

    initial begin
        int n;
        int gap;
        int mode;
        logic te;

        // Reset, then idle with t_enable every cycle
        for (int i = 0; i < 3; i++) step(1, 0, '0, 1);
        for (int i = 0; i < 200; i++) step(0, 0, '0, 1);

        // Single frame 8'hA5: load->start latency and busy length
        step(0, 1, 8'hA5, 1);
        n = 1;
        for (int i = 0; i < 10 && txd !== 1'b0; i++) begin step(0, 0, '0, 1); n++; end
        chk("start_latency", n, 2);
        for (int i = 0; i < 400 && busy !== 1'b0; i++) begin step(0, 0, '0, 1); n++; end
        chk("busy_drop_cycle", n, 162);

        // Back-to-back 8'h55 / 8'h0F with an overrun attempt of 8'hFF
        for (int i = 0; i < 5; i++) step(0, 0, '0, 1);
        tbr_rise_q.delete();
        step(0, 1, 8'h55, 1);
        for (int i = 0; i < 20 && tbr !== 1'b1; i++) step(0, 0, '0, 1);
        step(0, 1, 8'h0F, 1);
        chk("tbr_after_second_load", {31'd0, tbr}, 32'd0);
        step(0, 1, 8'hFF, 1);
        step(0, 1, 8'hFF, 1);
        for (int i = 0; i < 600 && busy !== 1'b0; i++) step(0, 0, '0, 1);
        chk("transfer_count", tbr_rise_q.size(), 2);
        gap = (tbr_rise_q.size() >= 2) ? tbr_rise_q[1] - tbr_rise_q[0] : -1;
        chk("frame_spacing", gap, FL * OS);

        // Sparse ticks (every 4th clk) and reset during data bit 3
        n = 0;
        step(0, 1, 8'($urandom), (n % 4) == 0); n++;
        for (int i = 0; i < 20 && txd !== 1'b0; i++) begin step(0, 0, '0, (n % 4) == 0); n++; end
        for (int i = 0; i < 64 * 4 + 30; i++) begin step(0, 0, '0, (n % 4) == 0); n++; end
        chk("busy_before_rst", {31'd0, busy}, 32'd1);
        step(1, 1, 8'h3C, (n % 4) == 0); n++;
        chk("rst_txd",  {31'd0, txd},  32'd1);
        chk("rst_tbr",  {31'd0, tbr},  32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 600; i++) begin step(0, 0, '0, (n % 4) == 0); n++; end

        // 8'h07: parity bit (when enabled) is 1
        step(0, 1, 8'h07, 1);
        for (int i = 0; i < 200; i++) step(0, 0, '0, 1);

        // Randomized traffic with varying tick patterns and rare resets
        mode = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) mode = int'($urandom_range(2));
            case (mode)
                0:       te = 1'b1;
                1:       te = 1'($urandom_range(1));
                default: te = (i % 3) == 0;
            endcase
            step($urandom_range(999) == 0, $urandom_range(7) == 0, 8'($urandom), te);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
